pc_gen: RTL and testbench

Parametrised fetch-address generator for the five-stage pipeline. It holds the fetch PC register, resolves D-stage branches and jumps on forwarded operands, and supports the full MIPS conditional-branch set (beq/bne/blez/bgtz/bltz/bgez) as well as j/jal/jr. It has a decode-stall hold and an optional exception/eret redirect with an internal EPC register. It sits between the F-stage instruction memory and the D-stage controller/forwarding muxes.

---
 rtl/pc_gen.sv | 80 ++++++++
 tb/tb_pc_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-PC register with D-stage branch/jump resolution and stall hold.
// Optional exception/eret redirect with internal EPC when PC_GEN_EXC_EN is defined.
module pc_gen #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [3:0]       br_op,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef PC_GEN_EXC_EN
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic [WIDTH-1:0] npc,
  output logic             taken,
  output logic             pc_misalign
);
  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic             misal_q;
  logic [WIDTH-1:0] pd4, br_tgt, j_tgt, target;
  logic signed [WIDTH-1:0] rs_s;
  assign pd4        = pc_d + WIDTH'(4);
  assign br_tgt     = pd4 + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign rs_s       = rs_val;
  assign pc_plus4_f = fpc_q + WIDTH'(4);
  assign pc_f       = fpc_q;
  assign npc        = fpc_d;
  assign pc_misalign = misal_q;
  // Jump keeps the upper PC bits above the 28-bit region; none remain at WIDTH 28.
  if (WIDTH > 28) begin : g_jhi
    assign j_tgt = {pd4[WIDTH-1:28], imm26, 2'b00};
  end else begin : g_jlo
    assign j_tgt = {imm26, 2'b00};
  end
  always_comb begin
    taken = 1'b0;
    case (br_op)
      4'd1:       taken = rs_val == rt_val;
      4'd2:       taken = rs_val != rt_val;
      4'd3:       taken = rs_s <= 0;
      4'd4:       taken = rs_s > 0;
      4'd5:       taken = rs_s < 0;
      4'd6:       taken = rs_s >= 0;
      4'd7, 4'd8: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end
  assign target = br_op == 4'd8 ? rs_val : br_op == 4'd7 ? j_tgt : br_tgt;
`ifdef PC_GEN_EXC_EN
  logic [WIDTH-1:0] epc_q, epc_d;
  assign epc   = epc_q;
  assign epc_d = exc_req ? exc_pc : epc_q;
  assign fpc_d = exc_req ? EXC_VEC : eret ? epc_q : stall ? fpc_q : taken ? target : pc_plus4_f;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) epc_q <= '0;
    else       epc_q <= epc_d;
  end
`else
  assign fpc_d = stall ? fpc_q : taken ? target : pc_plus4_f;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      misal_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      misal_q <= fpc_d[1:0] != 2'b00;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus for pc_gen, checked every cycle against a spec-level model.
module tb_pc_gen;
  logic        clk, reset, stall;
  logic [3:0]  br_op;
  logic [31:0] pc_d, rs_val, rt_val;
  logic [25:0] imm26;
  logic [31:0] pc_f, pc_plus4_f, npc;
  logic        taken, pc_misalign;
`ifdef PC_GEN_EXC_EN
  logic        exc_req, eret;
  logic [31:0] exc_pc, epc;
`endif
  int errors = 0, checks = 0;
  logic armed = 1'b0;
  logic [31:0] m_pc, m_epc;
  logic        m_mis;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .br_op(br_op), .pc_d(pc_d),
    .imm26(imm26), .rs_val(rs_val), .rt_val(rt_val),
`ifdef PC_GEN_EXC_EN
    .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret), .epc(epc),
`endif
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .npc(npc), .taken(taken),
    .pc_misalign(pc_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_taken(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = int'(rs);
    case (op)
      1: return rs == rt;
      2: return rs != rt;
      3: return s <= 0;
      4: return s > 0;
      5: return s < 0;
      6: return s >= 0;
      7, 8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [3:0] op, input logic [31:0] pcd,
                                           input logic [25:0] imm, input logic [31:0] rs);
    logic [31:0] pd4;
    shortint off;
    pd4 = pcd + 32'd4;
    off = shortint'(imm[15:0]);
    if (op == 8) return rs;
    if (op == 7) return (pd4 & 32'hF000_0000) | (32'(imm) * 4);
    return pd4 + 32'(int'(off) * 4);
  endfunction

  function automatic logic [31:0] m_npc();
`ifdef PC_GEN_EXC_EN
    if (exc_req) return 32'h0000_4180;
    if (eret) return m_epc;
`endif
    if (stall) return m_pc;
    if (m_taken(br_op, rs_val, rt_val)) return m_target(br_op, pc_d, imm26, rs_val);
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc  <= 32'h0000_3000;
      m_epc <= 32'h0;
      m_mis <= 1'b0;
    end else begin
      m_pc  <= m_npc();
      m_mis <= m_npc() % 4 != 0;
`ifdef PC_GEN_EXC_EN
      if (exc_req) m_epc <= exc_pc;
`endif
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_pc_f", pc_f, m_pc);
      chk("cyc_pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
      chk("cyc_npc", npc, m_npc());
      chk("cyc_taken", 32'(taken), 32'(m_taken(br_op, rs_val, rt_val)));
      chk("cyc_misalign", 32'(pc_misalign), 32'(m_mis));
`ifdef PC_GEN_EXC_EN
      chk("cyc_epc", epc, m_epc);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ops [4];
    logic       exp_a [4];
    logic       exp_b [4];
    ops   = '{4'd3, 4'd4, 4'd5, 4'd6};
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_b = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b0; stall = 1'b0; br_op = 4'd0; pc_d = '0; imm26 = '0; rs_val = '0; rt_val = '0;
`ifdef PC_GEN_EXC_EN
    exc_req = 1'b0; eret = 1'b0; exc_pc = '0;
`endif
    #1 reset = 1'b1;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_pc", pc_f, 32'h3000);
    chk("reset_misalign", 32'(pc_misalign), 32'h0);
    step(); chk("free1", pc_f, 32'h3004);
    step(); chk("free2", pc_f, 32'h3008);
    step(); chk("free3", pc_f, 32'h300C);
    #2 reset = 1'b1;
    #1 chk("async_reset", pc_f, 32'h3000);
    reset = 1'b0;
    step(); chk("after_async", pc_f, 32'h3004);
    br_op = 4'd1; pc_d = 32'h3010; rs_val = 32'd5; rt_val = 32'd5; imm26 = 26'h000FFFC;
    #1 chk("beq_taken", 32'(taken), 32'h1);
    chk("beq_npc", npc, 32'h3004);
    br_op = 4'd2;
    #1 chk("bne_taken", 32'(taken), 32'h0);
    chk("bne_npc", npc, 32'h3008);
    rs_val = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      br_op = ops[i];
      #1 chk($sformatf("neg_op%0d", ops[i]), 32'(taken), 32'(exp_a[i]));
    end
    rs_val = 32'h0;
    for (int i = 0; i < 4; i++) begin
      br_op = ops[i];
      #1 chk($sformatf("zero_op%0d", ops[i]), 32'(taken), 32'(exp_b[i]));
    end
    br_op = 4'd0;
    step();
    br_op = 4'd7; pc_d = 32'h3000_1000; imm26 = 26'h0000400;
    #1 chk("j_npc", npc, 32'h3000_1000);
    step(); chk("j_pc", pc_f, 32'h3000_1000);
    br_op = 4'd8; rs_val = 32'h3002;
    step(); br_op = 4'd0;
    chk("jr_pc", pc_f, 32'h3002);
    chk("jr_misalign", 32'(pc_misalign), 32'h1);
    br_op = 4'd1; pc_d = 32'h3010; rs_val = 32'd5; rt_val = 32'd5; imm26 = 26'h000FFFC; stall = 1'b1;
    step(); chk("stall1", pc_f, 32'h3002);
    step(); chk("stall2", pc_f, 32'h3002);
    stall = 1'b0;
    step(); chk("stall_release", pc_f, 32'h3004);
    chk("realigned", 32'(pc_misalign), 32'h0);
    br_op = 4'd0;
    step(); chk("post_seq", pc_f, 32'h3008);
`ifdef PC_GEN_EXC_EN
    exc_req = 1'b1; stall = 1'b1; exc_pc = 32'h3020;
    step(); exc_req = 1'b0; stall = 1'b0;
    chk("exc_pc_f", pc_f, 32'h4180);
    chk("exc_epc", epc, 32'h3020);
    eret = 1'b1;
    step(); eret = 1'b0;
    chk("eret_pc_f", pc_f, 32'h3020);
    exc_req = 1'b1; eret = 1'b1; exc_pc = 32'h3040;
    step(); exc_req = 1'b0; eret = 1'b0;
    chk("exc_eret_pc_f", pc_f, 32'h4180);
    chk("exc_eret_epc", epc, 32'h3040);
`endif
    step();
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
